des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
- Sequential DES subkey generator.
- Sits directly upstream of the S-box stage: each 48-bit subkey it emits is XORed with E(R) to form the eight 6-bit S-box addresses (S-box 4 takes subkey bits 19..24).
- Produces one subkey per accepted round, 16 rounds, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Consumer paces delivery with a valid/ready handshake.

Parameters:
- ROUNDS, 16, number of subkeys emitted per key load; fixed by DES, must not be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request, sampled only in IDLE.
- key  input  64  DES key; key[64] = DES bit 1 (MSB-first, [N:1] numbering); parity bits 8,16,…,64 ignored.
- decrypt  input  1  0 = K1..K16 order, 1 = K16..K1 order; sampled with start.
- subkey  output  48  current subkey; subkey[48] = PC-2 output bit 1.
- subkey_valid  output  1  subkey and round are valid.
- subkey_ready  input  1  consumer accepts the current subkey this cycle.
- round  output  4  round index of the current subkey, 0..15 (0 = first emitted).
- busy  output  1  high from start acceptance until the last handshake.
- done  output  1  one-cycle pulse in the cycle after the 16th handshake.

Behaviour:
- Reset: state IDLE; C, D, round, subkey_valid, busy and done all 0; subkey = 0. Reset takes priority over every other input, including mid-schedule; a partial schedule is abandoned with no done pulse.
- FSM states:
  - IDLE: on start=1, latch PC-1(key) into C/D (28 bits each), latch decrypt into dir, set round=0, go to RUN. busy rises in the cycle after start is sampled.
  - RUN: subkey_valid=1.
  - DONE: one cycle, done=1, busy=0, then IDLE.
- Shift schedule SHIFT[r] for encrypt round r = 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt mode: subkey for round r = PC-2(rotl(C,D) by cumulative SHIFT[0..r]).
  - First subkey appears the cycle after start, i.e. the rotate by SHIFT[0] happens on load (latency 1).
- Decrypt mode: subkey for round 0 = PC-2(C0,D0), with no rotation.
  - On each handshake at round r (r < 15), C and D rotate right by SHIFT[15-r] before the next subkey.
- subkey is combinational PC-2 of the C/D registers. It is stable while subkey_valid=1 and subkey_ready=0 (no change without a handshake).
- Handshake = subkey_valid & subkey_ready:
  - rounds 0..14: round increments and C/D rotate.
  - round 15: go to DONE; subkey_valid drops next cycle.
- Back-to-back: one subkey per cycle when subkey_ready is held high; 16 handshakes take 16 cycles.
- start while busy or in DONE: ignored, with no effect on key, dir or round.
- start asserted in the same cycle as done: ignored. A new start is accepted the following cycle, from IDLE.
- subkey_ready while subkey_valid=0: ignored.
- round wraps never: the last value is 15, then it holds until the next load.

Decomposition:
- Package des_pkg holds:
  - PC1 table (56 entries).
  - PC2 table (48 entries).
  - SHIFT table (16 entries).
  - Width constants KEY_W=64, HALF_W=28, SUBKEY_W=48.
  - State enum IDLE/RUN/DONE.
- Sub-module des_pc2: combinational 56→48 permutation. Reused later by a pipelined unrolled variant.
- PC-1 and the rotates stay inline.

Test Plan:
- Key 0x133457799BBCDFF1, decrypt=0, subkey_ready held 1 → subkey 0x1B02EFFC7072 with round=0 one cycle after start; 0x79AED9DBC9E5 at round=1; 0xCB3D8B0E17F5 at round=15; done one cycle later.
- Same key, decrypt=1 → round 0 = 0xCB3D8B0E17F5, round 14 = 0x79AED9DBC9E5, round 15 = 0x1B02EFFC7072; full sequence is the exact reverse of the encrypt capture.
- Encrypt run with subkey_ready toggled pseudo-randomly → subkey and round stable during stalls; exactly 16 distinct handshakes; sequence identical to the first test.
- start pulsed with a different key at round 5 and again in the done cycle → output sequence unchanged and no second run; start the cycle after done → new schedule begins.
- rst asserted at round 7 → next cycle subkey_valid=0, busy=0, round=0, no done; a subsequent start produces a correct fresh K1.
- Key 0x133457799BBCDFF1 with all parity bits flipped (XOR 0x0101010101010101) → identical subkeys to the first test.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, widths, FSM states and rotate helpers.
// Table entries use DES 1-based bit numbering (bit 1 = MSB).
package des_pkg;
   localparam int KEY_W    = 64;
   localparam int HALF_W   = 28;
   localparam int CD_W     = 2 * HALF_W;
   localparam int SUBKEY_W = 48;
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32};
   localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // DES bit 1 sits at the MSB, so a DES left rotate moves bits toward the MSB.
   function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input int n);
      return n == 2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction
   function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input int n);
      return n == 2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational PC-2 permutation, 56-bit C||D to 48-bit subkey.
// Ports: i_cd (C in [55:28], D in [27:0], MSB = DES bit 1), o_subkey (MSB = PC-2 bit 1).
module des_pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0]     i_cd,
   output logic [SUBKEY_W-1:0] o_subkey
);
   for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
      assign o_subkey[SUBKEY_W-1-i] = i_cd[CD_W-PC2[i]];
   end
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES subkey generator, one subkey per valid/ready handshake.
// Ports: clk, rst (sync, active-high); start/key/decrypt load a schedule from IDLE;
// subkey/subkey_valid/subkey_ready/round deliver K1..K16 (or K16..K1 when decrypting);
// busy spans start acceptance to the last handshake; done pulses one cycle afterwards.
module des_key_schedule
   import des_pkg::*;
#(
   parameter int ROUNDS = 16
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KEY_W-1:0]    key,
   input  logic                decrypt,
   output logic [SUBKEY_W-1:0] subkey,
   output logic                subkey_valid,
   input  logic                subkey_ready,
   output logic [3:0]          round,
   output logic                busy,
   output logic                done
);
   state_t            r_state;
   logic [HALF_W-1:0] r_c, r_d;
   logic              r_dir, r_valid, r_busy, r_done;
   logic [3:0]        r_round;
   logic [CD_W-1:0]   w_pc1;
   logic [HALF_W-1:0] w_c_ld, w_d_ld, w_c_nxt, w_d_nxt;
   int                w_sh;
   logic              w_unused_parity;
   // key[63] is DES bit 1, so DES bit n lives at key[64-n].
   for (genvar i = 0; i < CD_W; i++) begin : g_pc1
      assign w_pc1[CD_W-1-i] = key[KEY_W-PC1[i]];
   end
   assign w_unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
   // Encrypt applies the first rotate at load so K1 is ready the cycle after start;
   // decrypt starts from C0/D0, which equals C16/D16 since the shifts total 28.
   always_comb begin
      w_c_ld  = decrypt ? w_pc1[CD_W-1:HALF_W] : rotl28(w_pc1[CD_W-1:HALF_W], SHIFT[0]);
      w_d_ld  = decrypt ? w_pc1[HALF_W-1:0] : rotl28(w_pc1[HALF_W-1:0], SHIFT[0]);
      w_sh    = r_dir ? SHIFT[4'd15 - r_round] : SHIFT[r_round + 4'd1];
      w_c_nxt = r_dir ? rotr28(r_c, w_sh) : rotl28(r_c, w_sh);
      w_d_nxt = r_dir ? rotr28(r_d, w_sh) : rotl28(r_d, w_sh);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_dir   <= 1'b0;
         r_round <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_state <= RUN;
               r_c     <= w_c_ld;
               r_d     <= w_d_ld;
               r_dir   <= decrypt;
               r_round <= '0;
               r_valid <= 1'b1;
               r_busy  <= 1'b1;
            end
            RUN: if (r_valid && subkey_ready) begin
               if (r_round == 4'(ROUNDS - 1)) begin
                  r_state <= DONE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_round <= r_round + 4'd1;
                  r_c     <= w_c_nxt;
                  r_d     <= w_d_nxt;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   des_pc2 u_pc2 (
      .i_cd     ({r_c, r_d}),
      .o_subkey (subkey)
   );
   assign subkey_valid = r_valid;
   assign round        = r_round;
   assign busy         = r_busy;
   assign done         = r_done;
endmodule
